// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - memory-stage data responder with wait states, stall and fault reporting
module data_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  byteEnable,
    output logic [31:0] ReadDataM,
    output logic        MemStall,
    output logic        MemDone,
    output logic        MemFault
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [3:0]    r_count;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_write;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;
    logic          r_fault;
    logic [31:0]   r_mem [DEPTH];

    logic [AW-1:0] w_index;
    logic [31:0]   w_mask;
    logic          w_fault;
    logic          w_do_access;
    logic          w_do_write;

    // Decode of the latched request: word index, lane mask and legality.
    always_comb begin
        w_index = r_addr[AW+1:2];
        w_mask  = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
        w_fault = (r_addr >= 32'(DEPTH * 4))
                || ((r_be == 4'b1111) && (r_addr[1:0] != 2'b00))
                || (((r_be == 4'b0011) || (r_be == 4'b1100)) && r_addr[0]);
        w_do_access = (r_state == S_BUSY) && (r_count == 4'd0);
        w_do_write  = w_do_access && r_write && !w_fault;
    end

    // State register; reset aborts any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> BUSY on request, BUSY -> RESP when the wait count expires.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (MemReqM) w_next_state = S_BUSY;
            S_BUSY:  if (r_count == 4'd0) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_write <= 1'b0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && MemReqM) begin
                r_addr  <= ALUResultM;
                r_wdata <= WriteDataM;
                r_write <= MemWriteM;
                r_be    <= byteEnable;
                r_count <= 4'(WAIT_STATES);
            end else if ((r_state == S_BUSY) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end
            if (w_do_access) begin
                r_fault <= w_fault;
                if (w_fault) begin
                    r_rdata <= 32'd0;
                end else if (!r_write) begin
                    r_rdata <= r_mem[w_index] & w_mask;
                end
            end
        end
    end

    // RAM lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[w_index][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign MemStall  = ((r_state == S_IDLE) && MemReqM) || (r_state == S_BUSY);
    assign MemDone   = (r_state == S_RESP);
    assign MemFault  = (r_state == S_RESP) && r_fault;
    assign ReadDataM = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req2, we2, stall2, done2, fault2;
    logic [31:0] addr2, wd2, rd2;
    logic [3:0]  be2;
    logic        req0, we0, stall0, done0, fault0;
    logic [31:0] addr0, wd0, rd0;
    logic [3:0]  be0;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem2 [DEPTH];
    logic [31:0] mem0 [DEPTH];
    logic [31:0] last2 = 32'd0;
    logic [31:0] last0 = 32'd0;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_w2 (
        .clk(clk), .reset(reset), .MemReqM(req2), .MemWriteM(we2), .ALUResultM(addr2),
        .WriteDataM(wd2), .byteEnable(be2), .ReadDataM(rd2), .MemStall(stall2),
        .MemDone(done2), .MemFault(fault2)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_w0 (
        .clk(clk), .reset(reset), .MemReqM(req0), .MemWriteM(we0), .ALUResultM(addr0),
        .WriteDataM(wd0), .byteEnable(be0), .ReadDataM(rd0), .MemStall(stall0),
        .MemDone(done0), .MemFault(fault0)
    );

    function automatic logic is_fault(input logic [31:0] a, input logic [3:0] be);
        return (a >= 32'(DEPTH * 4)) || (be == 4'hF && a[1:0] != 2'd0)
            || ((be == 4'h3 || be == 4'hC) && a[0]);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: returns expected fault and the value ReadDataM holds afterwards.
    task automatic model(inout logic [31:0] mem [DEPTH], inout logic [31:0] last,
                         input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic exp_f);
        int w;
        exp_f = is_fault(a, be);
        w = int'(a >> 2);
        if (exp_f) last = 32'd0;
        else if (we) mem[w] = (mem[w] & ~lane_mask(be)) | (wd & lane_mask(be));
        else last = mem[w] & lane_mask(be);
    endtask

    // One access on the WAIT_STATES=2 instance, with inputs scrambled while busy.
    task automatic op2(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic flt);
        int   stalls;
        logic seen, exp_f;
        model(mem2, last2, we, a, wd, be, exp_f);
        @(negedge clk);
        req2 = 1'b1; we2 = we; addr2 = a; wd2 = wd; be2 = be;
        stalls = 0; seen = 1'b0; rd = 32'd0; flt = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall2) stalls++;
            if (done2) begin
                seen = 1'b1; rd = rd2; flt = fault2;
                break;
            end
            check("fault_outside_done", 32'(fault2), 32'd0);
            if (i > 0) begin
                addr2 = $urandom; wd2 = $urandom; be2 = 4'($urandom); we2 = 1'($urandom);
                req2 = 1'($urandom);
            end
            @(negedge clk);
        end
        req2 = 1'b0;
        check("done_seen", 32'(seen), 32'd1);
        check("stall_cycles", 32'(stalls), 32'd4);
        check("fault", 32'(flt), 32'(exp_f));
        check("read_data", rd, last2);
        @(negedge clk);
        #1;
        check("done_one_cycle", 32'(done2), 32'd0);
    endtask

    logic [31:0] rd;
    logic        flt;
    logic        b_we   [9];
    logic [31:0] b_addr [9];
    logic [31:0] b_wd   [9];
    logic [3:0]  b_be   [9];
    logic        b_f;
    int          k;

    initial begin
        reset = 1'b0;
        req2 = 0; we2 = 0; addr2 = 0; wd2 = 0; be2 = 0;
        req0 = 0; we0 = 0; addr0 = 0; wd0 = 0; be0 = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rd", rd2, 32'd0);
        check("rst_stall", 32'(stall2), 32'd0);
        check("rst_done", 32'(done2), 32'd0);
        check("rst_fault", 32'(fault2), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int w = 0; w < 16; w++) op2(1'b1, 32'(w * 4), $urandom | 32'h1, 4'hF, rd, flt);
        op2(1'b1, 32'hFFC, 32'hCAFE0001, 4'hF, rd, flt);

        op2(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, flt);
        op2(1'b0, 32'h10, 32'h0, 4'hF, rd, flt);
        check("round_trip", rd, 32'hDEADBEEF);
        check("round_trip_fault", 32'(flt), 32'd0);

        op2(1'b1, 32'h20, 32'h11223344, 4'hF, rd, flt);
        op2(1'b1, 32'h20, 32'hAABBCCDD, 4'b0100, rd, flt);
        op2(1'b0, 32'h20, 32'h0, 4'hF, rd, flt);
        check("partial_full", rd, 32'h11BB3344);
        op2(1'b0, 32'h20, 32'h0, 4'b0011, rd, flt);
        check("partial_low", rd, 32'h00003344);

        op2(1'b1, 32'h1000, 32'h12345678, 4'hF, rd, flt);
        check("oor_fault", 32'(flt), 32'd1);
        op2(1'b0, 32'h0, 32'h0, 4'hF, rd, flt);
        op2(1'b0, 32'hFFC, 32'h0, 4'hF, rd, flt);
        check("oor_last_word", rd, 32'hCAFE0001);

        op2(1'b0, 32'h22, 32'h0, 4'hF, rd, flt);
        check("misalign_fault", 32'(flt), 32'd1);
        check("misalign_rd", rd, 32'd0);

        op2(1'b0, 32'h24, 32'h0, 4'h0, rd, flt);
        check("be_zero_load", rd, 32'd0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 1) == 1) a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + 32'($urandom_range(0, 4095));
            op2(1'($urandom), a, $urandom, 4'($urandom), rd, flt);
        end

        // Back-to-back traffic on the zero-wait instance.
        for (int j = 0; j < 9; j++) begin
            b_we[j]   = (j < 4);
            b_addr[j] = (j < 4) ? 32'(j * 4) : (j < 8) ? 32'((j - 4) * 4) : 32'h4;
            b_wd[j]   = $urandom;
            b_be[j]   = (j < 8) ? 4'hF : 4'h0;
        end
        @(negedge clk);
        k = 0;
        req0 = 1'b1; we0 = b_we[0]; addr0 = b_addr[0]; wd0 = b_wd[0]; be0 = b_be[0];
        model(mem0, last0, b_we[0], b_addr[0], b_wd[0], b_be[0], b_f);
        for (int c = 0; c < 60 && k < 9; c++) begin
            #1;
            check("b2b_stall", 32'(stall0), 32'((c % 3) != 2));
            check("b2b_done", 32'(done0), 32'((c % 3) == 2));
            if (done0) begin
                check("b2b_rd", rd0, last0);
                check("b2b_fault", 32'(fault0), 32'd0);
                k++;
                if (k < 9) begin
                    we0 = b_we[k]; addr0 = b_addr[k]; wd0 = b_wd[k]; be0 = b_be[k];
                    model(mem0, last0, b_we[k], b_addr[k], b_wd[k], b_be[k], b_f);
                end else begin
                    req0 = 1'b0;
                end
            end
            @(negedge clk);
        end
        req0 = 1'b0;
        check("b2b_responses", 32'(k), 32'd9);

        // Reset while the store is in BUSY with one wait cycle left.
        op2(1'b0, 32'h14, 32'h0, 4'hF, rd, flt);
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h14; wd2 = ~mem2[5]; be2 = 4'hF;
        @(negedge clk);
        @(negedge clk);
        req2 = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_stall", 32'(stall2), 32'd0);
        check("abort_done", 32'(done2), 32'd0);
        check("abort_rd", rd2, 32'd0);
        last2 = 32'd0;
        last0 = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        op2(1'b0, 32'h14, 32'h0, 4'hF, rd, flt);
        check("abort_no_write", rd, mem2[5]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
